img_conv_stream: RTL and testbench
==================================

IMG_CONV_STREAM -- requirements
Module: img_conv_stream

Interface
REQ-001 Parameter DW, 16, pixel data width in bits.
REQ-002 Parameter IMG_W, 512, pixels per line (min 3).
REQ-003 Parameter IMG_H, 512, lines per frame (min 3).
REQ-004 Parameter K0..K8, 4,3,4,3,4,3,4,3,4, unsigned 4-bit kernel weights in raster order (K0 top-left, K4 centre, K8 bottom-right).
REQ-005 Parameter SHIFT, 5, right-shift normalisation applied to the weighted sum.
REQ-006 Ports: one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  asynchronous active-low reset.
REQ-009 ren  input  1  frame start request; sampled only in IDLE.
REQ-010 in_valid  input  1  pixel present on in_data.
REQ-011 in_data  input  DW  raster-order pixel.
REQ-012 in_ready  output  1  block accepts pixel this cycle.
REQ-013 out_valid  output  1  out_data holds a convolved pixel.
REQ-014 out_data  output  DW  convolved pixel.
REQ-015 out_ready  input  1  downstream accepts out_data.
REQ-016 o_en  output  1  one-cycle frame-done pulse.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states IDLE, RUN, FLUSH, DONE; IDLE->RUN on ren=1; RUN->FLUSH after pixel IMG_W*IMG_H accepted; FLUSH->DONE after last output handshake; DONE->IDLE unconditionally next cycle.
REQ-019 Input handshake completes when in_valid & in_ready; in_ready = (state==RUN) & (!out_valid | out_ready).
REQ-020 Two line buffers of IMG_W x DW plus a 3x3 window register hold the last three lines; the window shifts only on an input handshake.
REQ-021 Valid-window pixels only: an output is produced for each accepted pixel at column>=2 and row>=2; (IMG_W-2)*(IMG_H-2) outputs per frame, no border padding.
REQ-022 Accumulator width DW+8; sum = sum over Ki*window_i, exact, no overflow.
REQ-023 Latency: out_valid asserts 2 enabled cycles after the handshake of the window's bottom-right pixel (stage 1 sum, stage 2 shift/format).
REQ-024 When out_valid=1 and out_ready=0, out_data, out_valid and the whole pipeline hold unchanged.
REQ-025 Column/row counters wrap column IMG_W-1 -> 0, row increments; counters clear on entering RUN.
REQ-026 ren during RUN, FLUSH or DONE is ignored; in_valid outside RUN is ignored.
REQ-027 o_en pulses exactly one cycle, in DONE.

Reset
REQ-028 On rst=0: state IDLE, o_en=0, busy=0, in_ready=0, out_valid=0, out_data=0, counters 0, pipeline cleared; line-buffer contents undefined and unused until refilled.
REQ-029 Reset mid-frame aborts the frame; no o_en for it; the next frame needs a new ren.

Configuration
REQ-030 Macro IMG_CONV_SAT_EN defined: out_data = min(sum>>SHIFT, 2^DW-1).
REQ-031 IMG_CONV_SAT_EN undefined: out_data = low DW bits of sum>>SHIFT (wrap).

Structure
REQ-032 Shared package img_conv_pkg holds the FSM state typedef, the accumulator-width constant (DW+8) and the default kernel constants.
REQ-033 Sub-module img_line_buf: single-clock IMG_W-deep DW-wide delay line with enable, instantiated twice.

Verification
REQ-034 IMG_W=8, IMG_H=6, all pixels 1, SHIFT=5 -> 24 outputs, each 1, then one o_en pulse.
REQ-035 IMG_W=4, IMG_H=3, pixels 0..11, SHIFT=0 -> 2 outputs 160 and 192, latency 2 cycles after pixels 10 and 11.
REQ-036 All pixels 0xFFFF, SHIFT=0: with IMG_CONV_SAT_EN -> 0xFFFF; without -> 0xFFE0.
REQ-037 out_ready held 0 for 5 cycles mid-frame -> out_data stable, in_ready=0, no output lost or duplicated.
REQ-038 rst=0 after 20 pixels -> outputs cleared immediately, no o_en; new ren -> full correct frame.
REQ-039 ren pulsed during RUN -> ignored; output count and o_en unaffected.

Source files
------------

// File: rtl/img_conv_pkg.sv
// Shared types and constants for the streaming 3x3 image convolution block.
package img_conv_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFlush,
      StDone
   } conv_state_e;

   // Guard bits: 9 taps of 4-bit weights need at most 8 extra bits over DW.
   localparam int unsigned ACC_GUARD = 8;
   localparam int unsigned DEF_DW    = 16;
   localparam int unsigned DEF_ACC_W = DEF_DW + ACC_GUARD;

   localparam logic [3:0] DEF_K0 = 4'd4;
   localparam logic [3:0] DEF_K1 = 4'd3;
   localparam logic [3:0] DEF_K2 = 4'd4;
   localparam logic [3:0] DEF_K3 = 4'd3;
   localparam logic [3:0] DEF_K4 = 4'd4;
   localparam logic [3:0] DEF_K5 = 4'd3;
   localparam logic [3:0] DEF_K6 = 4'd4;
   localparam logic [3:0] DEF_K7 = 4'd3;
   localparam logic [3:0] DEF_K8 = 4'd4;

   function automatic int unsigned acc_width(input int unsigned dw);
      return dw + ACC_GUARD;
   endfunction

endpackage

// File: rtl/img_conv_stream_if.sv
// Pixel stream bundle: upstream pixel handshake plus downstream result handshake.
interface img_conv_stream_if #(
   parameter int unsigned DW = 16
) ();

   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

endinterface

// File: rtl/img_line_buf.sv
// DEPTH-entry delay line: o_data is the sample written DEPTH enabled cycles ago.
module img_line_buf #(
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 512
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_en,
   input  logic [DW-1:0] i_data,
   output logic [DW-1:0] o_data
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= '0;
      end else if (i_en) begin
         r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
      end
   end

   // Storage is not reset; contents are only consumed once refilled.
   always_ff @(posedge clk) begin
      if (i_en) begin
         r_mem[r_ptr] <= i_data;
      end
   end

   assign o_data = r_mem[r_ptr];

endmodule

// File: rtl/img_conv_stream.sv
// Streaming 3x3 convolution over a raster frame, valid windows only, 2-stage output pipe.
// Define IMG_CONV_SAT_EN to saturate the normalised sum instead of wrapping it.
module img_conv_stream
   import img_conv_pkg::*;
#(
   parameter int unsigned DW    = DEF_DW,
   parameter int unsigned IMG_W = 512,
   parameter int unsigned IMG_H = 512,
   parameter logic [3:0]  K0    = DEF_K0,
   parameter logic [3:0]  K1    = DEF_K1,
   parameter logic [3:0]  K2    = DEF_K2,
   parameter logic [3:0]  K3    = DEF_K3,
   parameter logic [3:0]  K4    = DEF_K4,
   parameter logic [3:0]  K5    = DEF_K5,
   parameter logic [3:0]  K6    = DEF_K6,
   parameter logic [3:0]  K7    = DEF_K7,
   parameter logic [3:0]  K8    = DEF_K8,
   parameter int unsigned SHIFT = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ren,
   img_conv_stream_if.slave       bus,
   output logic                   o_en,
   output logic                   busy
);

   localparam int unsigned ACC_W = acc_width(DW);
   localparam int unsigned CW    = $clog2(IMG_W);
   localparam int unsigned RW    = $clog2(IMG_H + 1);
   localparam logic [3:0]  KW [9] = '{K0, K1, K2, K3, K4, K5, K6, K7, K8};

   conv_state_e      r_state;
   conv_state_e      w_state_nxt;
   logic [CW-1:0]    r_col;
   logic [RW-1:0]    r_row;
   logic [DW-1:0]    r_win [9];
   logic             r_win_vld;
   logic             r_s1_vld;
   logic [ACC_W-1:0] r_s1_sum;
   logic             r_out_valid;
   logic [DW-1:0]    r_out_data;

   logic             w_adv;
   logic             w_in_ready;
   logic             w_hs;
   logic             w_start;
   logic             w_last;
   logic             w_win_ok;
   logic             w_flush_done;
   logic [DW-1:0]    w_lb0;
   logic [DW-1:0]    w_lb1;
   logic [ACC_W-1:0] w_sum;
   logic [DW-1:0]    w_fmt;

   // The whole pipeline freezes while a result waits for the consumer.
   assign w_adv        = !r_out_valid || bus.out_ready;
   assign w_in_ready   = (r_state == StRun) && w_adv;
   assign w_hs         = bus.in_valid && w_in_ready;
   assign w_start      = (r_state == StIdle) && ren;
   assign w_last       = (r_col == CW'(IMG_W - 1)) && (r_row == RW'(IMG_H - 1));
   assign w_win_ok     = (r_col >= CW'(2)) && (r_row >= RW'(2));
   assign w_flush_done = !r_win_vld && !r_s1_vld && (!r_out_valid || bus.out_ready);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (ren) w_state_nxt = StRun;
         StRun:   if (w_hs && w_last) w_state_nxt = StFlush;
         StFlush: if (w_flush_done) w_state_nxt = StDone;
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_start) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_hs) begin
         if (r_col == CW'(IMG_W - 1)) begin
            r_col <= '0;
            r_row <= r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   // lb0 yields the pixel one line above the incoming one, lb1 two lines above.
   img_line_buf #(
      .DW    (DW),
      .DEPTH (IMG_W)
   ) u_lb0 (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_hs),
      .i_data (bus.in_data),
      .o_data (w_lb0)
   );

   img_line_buf #(
      .DW    (DW),
      .DEPTH (IMG_W)
   ) u_lb1 (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_hs),
      .i_data (w_lb0),
      .o_data (w_lb1)
   );

   // Window in raster order; column 2 is the newest, row 2 the current line.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 9; i++) r_win[i] <= '0;
      end else if (w_hs) begin
         for (int r = 0; r < 3; r++) begin
            r_win[r*3]     <= r_win[r*3 + 1];
            r_win[r*3 + 1] <= r_win[r*3 + 2];
         end
         r_win[2] <= w_lb1;
         r_win[5] <= w_lb0;
         r_win[8] <= bus.in_data;
      end
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < 9; i++) begin
         w_sum = w_sum + ACC_W'(KW[i]) * ACC_W'(r_win[i]);
      end
   end

`ifdef IMG_CONV_SAT_EN
   logic [ACC_W-1:0] w_shifted;
   assign w_shifted = r_s1_sum >> SHIFT;
   assign w_fmt     = (|w_shifted[ACC_W-1:DW]) ? {DW{1'b1}} : w_shifted[DW-1:0];
`else
   assign w_fmt = DW'(r_s1_sum >> SHIFT);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_win_vld   <= 1'b0;
         r_s1_vld    <= 1'b0;
         r_s1_sum    <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_adv) begin
         r_win_vld   <= w_hs && w_win_ok;
         r_s1_vld    <= r_win_vld;
         r_out_valid <= r_s1_vld;
         if (r_win_vld) r_s1_sum <= w_sum;
         if (r_s1_vld) r_out_data <= w_fmt;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign o_en          = (r_state == StDone);
   assign busy          = (r_state != StIdle);

endmodule

// File: tb/tb_img_conv_stream.sv
// Bench for img_conv_stream: an 8x6/SHIFT=5 instance and a 4x3/SHIFT=0 instance vs a frame model.
module tb_img_conv_stream;

   localparam int unsigned DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          sel;
   logic          ren_d       [2];
   logic          in_valid_d  [2];
   logic          out_ready_d [2];
   logic [DW-1:0] in_data_d   [2];
   logic          oen_a, oen_b, busy_a, busy_b;

   img_conv_stream_if #(.DW(DW)) if_a ();
   img_conv_stream_if #(.DW(DW)) if_b ();

   assign if_a.in_valid  = in_valid_d[0];
   assign if_a.in_data   = in_data_d[0];
   assign if_a.out_ready = out_ready_d[0];
   assign if_b.in_valid  = in_valid_d[1];
   assign if_b.in_data   = in_data_d[1];
   assign if_b.out_ready = out_ready_d[1];

   img_conv_stream #(.DW(DW), .IMG_W(8), .IMG_H(6), .SHIFT(5)) u_dut_a (
      .clk  (clk),
      .rst  (rst),
      .ren  (ren_d[0]),
      .bus  (if_a.slave),
      .o_en (oen_a),
      .busy (busy_a)
   );

   img_conv_stream #(.DW(DW), .IMG_W(4), .IMG_H(3), .SHIFT(0)) u_dut_b (
      .clk  (clk),
      .rst  (rst),
      .ren  (ren_d[1]),
      .bus  (if_b.slave),
      .o_en (oen_b),
      .busy (busy_b)
   );

   wire          m_in_ready  = sel ? if_b.in_ready  : if_a.in_ready;
   wire          m_out_valid = sel ? if_b.out_valid : if_a.out_valid;
   wire [DW-1:0] m_out_data  = sel ? if_b.out_data  : if_a.out_data;
   wire          m_o_en      = sel ? oen_b : oen_a;
   wire          m_busy      = sel ? busy_b : busy_a;

   always #5 clk = ~clk;

   int            n_chk = 0;
   int            n_pass = 0;
   int            cyc = 0;
   int            oen_cnt = 0;
   bit            p_valid, p_ready, last_acc;
   logic [DW-1:0] pix[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] obs_q[$];
   int            hs_t[$];
   int            out_t[$];
   int            kw [9] = '{4, 3, 4, 3, 4, 3, 4, 3, 4};

   function automatic int img_w(input logic s); return s ? 4 : 8; endfunction
   function automatic int img_h(input logic s); return s ? 3 : 6; endfunction
   function automatic int img_sh(input logic s); return s ? 0 : 5; endfunction

   // Reference: direct 3x3 dot product over each fully-inside window of the frame.
   function automatic void build_expected(input logic s);
      int     w  = img_w(s);
      int     h  = img_h(s);
      longint acc;
      exp_q.delete();
      for (int y = 2; y < h; y++) begin
         for (int x = 2; x < w; x++) begin
            acc = 0;
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  acc += kw[r*3 + c] * longint'(pix[(y - 2 + r) * w + x - 2 + c]);
            acc = acc >> img_sh(s);
`ifdef IMG_CONV_SAT_EN
            if (acc > 65535) acc = 65535;
`endif
            exp_q.push_back(acc[15:0]);
         end
      end
   endfunction

   // One clock: observe the selected instance just before the edge, then step past it.
   task automatic tick();
      @(negedge clk);
      last_acc = in_valid_d[sel] && m_in_ready;
      if (last_acc) hs_t.push_back(cyc + 1);
      if (m_out_valid && !(p_valid && !p_ready)) out_t.push_back(cyc);
      if (m_out_valid && out_ready_d[sel]) obs_q.push_back(m_out_data);
      if (m_o_en) oen_cnt++;
      p_valid = m_out_valid;
      p_ready = out_ready_d[sel];
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic fill_rand(input logic s);
      pix.delete();
      for (int i = 0; i < img_w(s) * img_h(s); i++) pix.push_back(DW'($urandom_range(0, 65535)));
   endtask

   task automatic run_frame(input logic s, input int vprob, input int rprob, input int stall_at,
                            input int ren_at, input int rst_at, input string name);
      int            n = img_w(s) * img_h(s);
      int            idx = 0;
      int            budget = 0;
      int            stall_left = 0;
      bit            stalled = 0;
      logic [DW-1:0] held = '0;
      sel = s;
      build_expected(s);
      obs_q.delete(); hs_t.delete(); out_t.delete();
      oen_cnt = 0; p_valid = 0; p_ready = 0;
      ren_d[s] = 1'b1;
      tick();
      ren_d[s] = 1'b0;
      n_chk++;
      if (m_busy !== 1'b1) $display("FAIL %s busy_after_ren: got %b want 1", name, m_busy);
      else n_pass++;
      while (oen_cnt == 0 && budget < 4000) begin
         if (rst_at >= 0 && idx == rst_at) begin
            rst = 1'b0;
            in_valid_d[s] = 1'b0;
            #1;
            n_chk++;
            if (m_out_valid !== 1'b0) $display("FAIL %s rst_out_valid: got %b want 0", name, m_out_valid);
            else n_pass++;
            n_chk++;
            if (m_out_data !== '0) $display("FAIL %s rst_out_data: got %h want 0", name, m_out_data);
            else n_pass++;
            n_chk++;
            if (m_in_ready !== 1'b0) $display("FAIL %s rst_in_ready: got %b want 0", name, m_in_ready);
            else n_pass++;
            n_chk++;
            if (m_busy !== 1'b0 || m_o_en !== 1'b0)
               $display("FAIL %s rst_busy_oen: got %b%b want 00", name, m_busy, m_o_en);
            else n_pass++;
            return;
         end
         in_valid_d[s]  = (idx < n) && ($urandom_range(0, 99) < vprob);
         in_data_d[s]   = (idx < n) ? pix[idx] : '0;
         out_ready_d[s] = ($urandom_range(0, 99) < rprob);
         ren_d[s]       = (budget == ren_at);
         if (stall_at >= 0 && !stalled && m_out_valid && obs_q.size() >= stall_at) begin
            stalled    = 1;
            stall_left = 5;
            held       = m_out_data;
         end
         if (stall_left > 0) begin
            out_ready_d[s] = 1'b0;
            in_valid_d[s]  = (idx < n);
            #1;
            n_chk++;
            if (m_out_valid !== 1'b1 || m_out_data !== held)
               $display("FAIL %s stall_hold: got %b/%h want 1/%h", name, m_out_valid, m_out_data, held);
            else n_pass++;
            n_chk++;
            if (m_in_ready !== 1'b0) $display("FAIL %s stall_in_ready: got %b want 0", name, m_in_ready);
            else n_pass++;
            stall_left--;
         end
         tick();
         if (last_acc) idx++;
         budget++;
      end
      in_valid_d[s] = 1'b0; out_ready_d[s] = 1'b1; ren_d[s] = 1'b0;
      repeat (4) tick();
      n_chk++;
      if (budget >= 4000) $display("FAIL %s timeout: got no o_en after %0d cycles, want o_en", name, budget);
      else n_pass++;
      n_chk++;
      if (obs_q.size() !== exp_q.size())
         $display("FAIL %s out_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         n_chk++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
            $display("FAIL %s out[%0d]: got %h want %h", name, i,
                     (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, exp_q[i]);
         else n_pass++;
      end
      n_chk++;
      if (oen_cnt !== 1) $display("FAIL %s o_en_pulses: got %0d want 1", name, oen_cnt);
      else n_pass++;
      n_chk++;
      if (m_busy !== 1'b0) $display("FAIL %s busy_at_end: got %b want 0", name, m_busy);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b0; sel = 1'b0;
      for (int i = 0; i < 2; i++) begin
         ren_d[i] = 1'b0; in_valid_d[i] = 1'b0; out_ready_d[i] = 1'b1; in_data_d[i] = '0;
      end
      #1;
      n_chk++;
      if ({busy_a, oen_a, if_a.in_ready, if_a.out_valid} !== 4'b0)
         $display("FAIL reset_a_ctrl: got %b want 0000", {busy_a, oen_a, if_a.in_ready, if_a.out_valid});
      else n_pass++;
      n_chk++;
      if (if_a.out_data !== '0) $display("FAIL reset_a_data: got %h want 0", if_a.out_data);
      else n_pass++;
      n_chk++;
      if ({busy_b, oen_b, if_b.in_ready, if_b.out_valid} !== 4'b0)
         $display("FAIL reset_b_ctrl: got %b want 0000", {busy_b, oen_b, if_b.in_ready, if_b.out_valid});
      else n_pass++;
      n_chk++;
      if (if_b.out_data !== '0) $display("FAIL reset_b_data: got %h want 0", if_b.out_data);
      else n_pass++;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      in_valid_d[0] = 1'b1; in_data_d[0] = 16'h1234;
      #1;
      n_chk++;
      if (if_a.in_ready !== 1'b0) $display("FAIL idle_in_ready: got %b want 0", if_a.in_ready);
      else n_pass++;
      repeat (3) tick();
      n_chk++;
      if (busy_a !== 1'b0 || if_a.out_valid !== 1'b0)
         $display("FAIL idle_ignores_valid: got busy=%b ov=%b want 0/0", busy_a, if_a.out_valid);
      else n_pass++;
      in_valid_d[0] = 1'b0;
      tick();
   endtask

   task automatic test_ones();
      pix.delete();
      for (int i = 0; i < 48; i++) pix.push_back(16'd1);
      run_frame(1'b0, 100, 100, -1, -1, -1, "ones");
      n_chk++;
      if (obs_q.size() !== 24 || obs_q[0] !== 16'd1)
         $display("FAIL ones_const: got %0d outputs first %h want 24 outputs of 1", obs_q.size(), obs_q[0]);
      else n_pass++;
   endtask

   task automatic test_ramp_latency();
      pix.delete();
      for (int i = 0; i < 12; i++) pix.push_back(DW'(i));
      run_frame(1'b1, 100, 100, -1, -1, -1, "ramp");
      n_chk++;
      if (obs_q.size() < 2 || obs_q[0] !== 16'd160 || obs_q[1] !== 16'd192)
         $display("FAIL ramp_values: got %0d outputs %h %h want 160 192", obs_q.size(), obs_q[0], obs_q[1]);
      else n_pass++;
      n_chk++;
      if (hs_t.size() < 12 || out_t.size() < 2 || out_t[0] - hs_t[10] !== 2)
         $display("FAIL ramp_latency0: got %0d want 2", (out_t.size() > 0 && hs_t.size() > 10) ? out_t[0] - hs_t[10] : -1);
      else n_pass++;
      n_chk++;
      if (hs_t.size() < 12 || out_t.size() < 2 || out_t[1] - hs_t[11] !== 2)
         $display("FAIL ramp_latency1: got %0d want 2", (out_t.size() > 1 && hs_t.size() > 11) ? out_t[1] - hs_t[11] : -1);
      else n_pass++;
   endtask

   task automatic test_overflow();
      logic [DW-1:0] want;
`ifdef IMG_CONV_SAT_EN
      want = 16'hFFFF;
`else
      want = 16'hFFE0;
`endif
      pix.delete();
      for (int i = 0; i < 12; i++) pix.push_back(16'hFFFF);
      run_frame(1'b1, 100, 100, -1, -1, -1, "overflow");
      n_chk++;
      if (obs_q.size() < 1 || obs_q[0] !== want)
         $display("FAIL overflow_value: got %h want %h", obs_q[0], want);
      else n_pass++;
   endtask

   task automatic test_random();
      fill_rand(1'b0);
      run_frame(1'b0, 55, 65, -1, -1, -1, "rand_a0");
      fill_rand(1'b0);
      run_frame(1'b0, 80, 40, -1, -1, -1, "rand_a1");
      fill_rand(1'b1);
      run_frame(1'b1, 60, 60, -1, -1, -1, "rand_b");
   endtask

   task automatic test_backpressure();
      fill_rand(1'b0);
      run_frame(1'b0, 100, 100, 3, -1, -1, "stall");
   endtask

   task automatic test_ren_in_run();
      fill_rand(1'b0);
      run_frame(1'b0, 100, 100, -1, 10, -1, "ren_in_run");
   endtask

   task automatic test_reset_mid_frame();
      fill_rand(1'b0);
      run_frame(1'b0, 100, 100, -1, -1, 20, "mid_rst");
      repeat (3) tick();
      rst = 1'b1;
      repeat (5) tick();
      n_chk++;
      if (oen_cnt !== 0 || busy_a !== 1'b0)
         $display("FAIL mid_rst_aftermath: got o_en=%0d busy=%b want 0/0", oen_cnt, busy_a);
      else n_pass++;
      fill_rand(1'b0);
      run_frame(1'b0, 70, 70, -1, -1, -1, "after_rst");
   endtask

   initial begin
      test_reset();
      test_ones();
      test_ramp_latency();
      test_overflow();
      test_random();
      test_backpressure();
      test_ren_in_run();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
